// File: rtl/h14tx_pkg.sv
// Shared types and phase lengths for the HDMI 1.4 transmit path.
// The island phase enum is used by the scheduler and its consumers.
package h14tx_pkg;

    typedef enum logic [2:0] {
        IslIdle,
        IslPreamble,
        IslLeadGuard,
        IslPacket,
        IslTrailGuard
    } island_phase_t;

    localparam int IslPreambleLen = 8;
    localparam int IslGuardLen    = 2;
    localparam int IslPacketLen   = 32;

endpackage

// File: rtl/h14tx_rr_arbiter.sv
// Combinational round-robin picker.
// Returns the first set mask bit at or after pointer, wrapping modulo N.
module h14tx_rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         mask,
    input  logic [$clog2(N)-1:0] pointer,
    output logic [N-1:0]         pick,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);

    localparam int PW = $clog2(N);

    int j;

    always_comb begin
        pick = '0;
        idx  = '0;
        any  = 1'b0;
        j    = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(pointer) + i) % N;
            if (!any && mask[j]) begin
                any     = 1'b1;
                pick[j] = 1'b1;
                idx     = PW'(j);
            end
        end
    end

endmodule

// File: rtl/h14tx_island_scheduler.sv
// Data-island scheduler: places one island per line in horizontal blanking
// and shares its 32-clock packet slots between requesters round-robin.
module h14tx_island_scheduler
    import h14tx_pkg::*;
#(
    parameter int BitWidth    = 11,
    parameter int NumReq      = 4,
    parameter int FrameWidth  = 1650,
    parameter int IslandStart = 1290,
    parameter int MaxPackets  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [BitWidth-1:0] x,
    input  logic [NumReq-1:0]   req,
    output logic [NumReq-1:0]   ack,
    output logic [NumReq-1:0]   grant,
    output island_phase_t       phase,
    output logic [4:0]          byte_idx
);

    localparam int PW  = $clog2(NumReq);
    localparam int PSW = $clog2(MaxPackets + 1);

    if (IslandStart + 1 + IslPreambleLen + 2 * IslGuardLen
        + IslPacketLen * MaxPackets > FrameWidth) begin : g_bad_frame
        $error("island does not fit in the line");
    end
    if (NumReq < 2 || NumReq > 8) begin : g_bad_numreq
        $error("NumReq out of range 2..8");
    end
    if (MaxPackets < 1 || MaxPackets > 18) begin : g_bad_maxpk
        $error("MaxPackets out of range 1..18");
    end

    island_phase_t   phase_q, phase_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [4:0]      byte_idx_q, byte_idx_d;
    logic [NumReq-1:0] grant_q, grant_d;
    logic [NumReq-1:0] ack_q, ack_d;
    logic [NumReq-1:0] snap_q, snap_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PSW-1:0]  sent_q, sent_d;

    logic [NumReq-1:0] cand;
    logic [NumReq-1:0] pick;
    logic [PW-1:0]     pick_idx;
    logic              pick_any;
    logic              start_pkt;

    assign cand = snap_q & req;

    h14tx_rr_arbiter #(
        .N(NumReq)
    ) u_arb (
        .mask   (cand),
        .pointer(ptr_q),
        .pick   (pick),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        byte_idx_d = byte_idx_q;
        grant_d    = grant_q;
        ack_d      = '0;
        snap_d     = snap_q;
        ptr_d      = ptr_q;
        sent_d     = sent_q;
        start_pkt  = 1'b0;

        unique case (phase_q)
            IslIdle: begin
                if (x == BitWidth'(IslandStart) && en && |req) begin
                    phase_d = IslPreamble;
                    cnt_d   = 5'(IslPreambleLen - 1);
                    snap_d  = req;
                    sent_d  = '0;
                end
            end
            IslPreamble: begin
                if (cnt_q == 5'd0) begin
                    phase_d = IslLeadGuard;
                    cnt_d   = 5'(IslGuardLen - 1);
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            IslLeadGuard: begin
                if (cnt_q == 5'd0) begin
                    start_pkt = 1'b1;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            IslPacket: begin
                cnt_d      = cnt_q - 5'd1;
                byte_idx_d = byte_idx_q + 5'd1;
                // Registered ack must land on the packet's final clock.
                if (cnt_q == 5'd1) begin
                    ack_d = grant_q;
                end
                if (cnt_q == 5'd0) begin
                    if (|cand && sent_q < PSW'(MaxPackets)) begin
                        start_pkt = 1'b1;
                    end else begin
                        phase_d    = IslTrailGuard;
                        cnt_d      = 5'(IslGuardLen - 1);
                        byte_idx_d = '0;
                        grant_d    = '0;
                    end
                end
            end
            IslTrailGuard: begin
                if (cnt_q == 5'd0) begin
                    phase_d = IslIdle;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            default: begin
                phase_d = IslIdle;
            end
        endcase

        // An empty candidate mask still yields a (null) packet slot.
        if (start_pkt) begin
            phase_d    = IslPacket;
            cnt_d      = 5'(IslPacketLen - 1);
            byte_idx_d = '0;
            grant_d    = pick;
            sent_d     = sent_q + 1'b1;
            if (pick_any) begin
                snap_d = snap_q & ~pick;
                ptr_d  = (pick_idx == PW'(NumReq - 1)) ? '0 : pick_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q    <= IslIdle;
            cnt_q      <= '0;
            byte_idx_q <= '0;
            grant_q    <= '0;
            ack_q      <= '0;
            snap_q     <= '0;
            ptr_q      <= '0;
            sent_q     <= '0;
        end else begin
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            byte_idx_q <= byte_idx_d;
            grant_q    <= grant_d;
            ack_q      <= ack_d;
            snap_q     <= snap_d;
            ptr_q      <= ptr_d;
            sent_q     <= sent_d;
        end
    end

    assign phase    = phase_q;
    assign grant    = grant_q;
    assign ack      = ack_q;
    assign byte_idx = byte_idx_q;

endmodule

// File: tb/tb_h14tx_island_scheduler.sv
// Self-checking bench for h14tx_island_scheduler.
// A line-level schedule model predicts every output cycle from the req/en tables.
module tb_h14tx_island_scheduler;
    import h14tx_pkg::*;

    localparam int FW   = 1650;
    localparam int IS   = 1290;
    localparam int NR   = 4;
    localparam int MAXP = 2;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic [10:0]   x;
    logic [NR-1:0] req;
    logic [NR-1:0] ack;
    logic [NR-1:0] grant;
    island_phase_t phase;
    logic [4:0]    byte_idx;

    h14tx_island_scheduler #(
        .BitWidth   (11),
        .NumReq     (NR),
        .FrameWidth (FW),
        .IslandStart(IS),
        .MaxPackets (MAXP)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .x       (x),
        .req     (req),
        .ack     (ack),
        .grant   (grant),
        .phase   (phase),
        .byte_idx(byte_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [NR-1:0] req_tab [FW];
    logic          en_tab  [FW];
    island_phase_t exp_phase [FW];
    logic [NR-1:0] exp_grant [FW];
    logic [NR-1:0] exp_ack   [FW];
    logic [4:0]    exp_bidx  [FW];
    int            m_ptr;

    int            line_acks;
    int            line_busy;
    logic [NR-1:0] grant_seq [$];

    // Line schedule from the rules: fixed phase spans, one 32-clock slot
    // per packet, grant chosen from snapshot & req one clock before each slot.
    function automatic void build_model();
        logic [NR-1:0] snap, mask, g;
        int s, k, j;
        for (int i = 0; i < FW; i++) begin
            exp_phase[i] = IslIdle;
            exp_grant[i] = '0;
            exp_ack[i]   = '0;
            exp_bidx[i]  = '0;
        end
        if (!(en_tab[IS] && req_tab[IS] != 0)) return;
        snap = req_tab[IS];
        for (int i = IS + 1; i <= IS + 8; i++) exp_phase[i] = IslPreamble;
        for (int i = IS + 9; i <= IS + 10; i++) exp_phase[i] = IslLeadGuard;
        s = IS + 11;
        k = 0;
        while (1) begin
            mask = snap & req_tab[s - 1];
            if (k > 0 && (mask == 0 || k >= MAXP)) break;
            g = '0;
            for (int i = 0; i < NR; i++) begin
                j = (m_ptr + i) % NR;
                if (g == 0 && mask[j]) g[j] = 1'b1;
            end
            if (g != 0) begin
                snap = snap & ~g;
                for (int i = 0; i < NR; i++) if (g[i]) m_ptr = (i + 1) % NR;
            end
            for (int i = 0; i < 32; i++) begin
                exp_phase[s + i] = IslPacket;
                exp_grant[s + i] = g;
                exp_bidx[s + i]  = 5'(i);
            end
            exp_ack[s + 31] = g;
            s += 32;
            k++;
        end
        exp_phase[s]     = IslTrailGuard;
        exp_phase[s + 1] = IslTrailGuard;
    endfunction

    function automatic void fill(input logic [NR-1:0] r, input logic e);
        for (int i = 0; i < FW; i++) begin
            req_tab[i] = r;
            en_tab[i]  = e;
        end
    endfunction

    task automatic run_line(input int last_v);
        int k;
        line_acks = 0;
        line_busy = 0;
        grant_seq.delete();
        for (int v = 0; v <= last_v; v++) begin
            x   = 11'(v);
            req = req_tab[v];
            en  = en_tab[v];
            @(posedge clk);
            @(negedge clk);
            k = (v + 1) % FW;
            n_tests++;
            if (phase !== exp_phase[k] || grant !== exp_grant[k] ||
                ack !== exp_ack[k] || byte_idx !== exp_bidx[k]) begin
                n_fail++;
                $display("FAIL cycle x=%0d got ph=%0d g=%b a=%b b=%0d want ph=%0d g=%b a=%b b=%0d",
                         k, phase, grant, ack, byte_idx,
                         exp_phase[k], exp_grant[k], exp_ack[k], exp_bidx[k]);
            end
            if (ack != 0) line_acks++;
            if (phase != IslIdle) line_busy++;
            if (grant != 0 && byte_idx == 5'd0) grant_seq.push_back(grant);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        x     = '0;
        req   = '0;
        en    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        x = '0; req = '0; en = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (phase !== IslIdle || grant !== 4'b0 || ack !== 4'b0 || byte_idx !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_state got ph=%0d g=%b a=%b b=%0d want idle/0/0/0",
                     phase, grant, ack, byte_idx);
        end
        rst_n = 1'b1;
        m_ptr = 0;
        @(negedge clk);

        fill(4'b1111, 1'b1);
        build_model();
        run_line(IS + 20);
        n_tests++;
        if (byte_idx !== 5'd10) begin
            n_fail++;
            $display("FAIL reset_pre_byte got %0d want 10", byte_idx);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (phase !== IslIdle || grant !== 4'b0 || ack !== 4'b0 || byte_idx !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_abort got ph=%0d g=%b a=%b b=%0d want idle/0/0/0",
                     phase, grant, ack, byte_idx);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 0;

        build_model();
        run_line(FW - 1);
        n_tests++;
        if (grant_seq.size() < 1 || grant_seq[0] !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_first_grant got %b want 0001",
                     grant_seq.size() > 0 ? grant_seq[0] : 4'bx);
        end
    endtask

    task automatic test_single();
        fill(4'b0100, 1'b1);
        build_model();
        run_line(FW - 1);
        n_tests++;
        if (line_acks !== 1 || grant_seq.size() !== 1 || line_busy !== 44) begin
            n_fail++;
            $display("FAIL single acks=%0d pkts=%0d busy=%0d want 1/1/44",
                     line_acks, grant_seq.size(), line_busy);
        end
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] want [6];
        want = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        apply_reset();
        fill(4'b1111, 1'b1);
        for (int l = 0; l < 3; l++) begin
            build_model();
            run_line(FW - 1);
            n_tests++;
            if (line_acks !== 2 || grant_seq.size() !== 2 ||
                grant_seq[0] !== want[2*l] || grant_seq[1] !== want[2*l+1]) begin
                n_fail++;
                $display("FAIL rr_line%0d acks=%0d pkts=%0d want acks 2 order %b,%b",
                         l, line_acks, grant_seq.size(), want[2*l], want[2*l+1]);
            end
        end
    endtask

    task automatic test_empty();
        for (int c = 0; c < 3; c++) begin
            if (c == 0) fill(4'b0000, 1'b1);
            else fill(4'b1111, 1'b0);
            if (c == 2) for (int i = IS + 1; i < FW; i++) en_tab[i] = 1'b1;
            build_model();
            run_line(FW - 1);
            n_tests++;
            if (line_busy !== 0) begin
                n_fail++;
                $display("FAIL empty_case%0d busy cycles=%0d want 0", c, line_busy);
            end
        end
    endtask

    task automatic test_early_drop();
        fill(4'b0011, 1'b1);
        for (int i = 1295; i < FW; i++) req_tab[i] = 4'b0000;
        build_model();
        run_line(FW - 1);
        n_tests++;
        if (line_acks !== 0 || grant_seq.size() !== 0 || line_busy !== 44) begin
            n_fail++;
            $display("FAIL early_drop acks=%0d grants=%0d busy=%0d want 0/0/44",
                     line_acks, grant_seq.size(), line_busy);
        end
    endtask

    task automatic test_late_request();
        int seen;
        fill(4'b0001, 1'b1);
        for (int i = 1310; i < FW; i++) req_tab[i] = 4'b0101;
        build_model();
        run_line(FW - 1);
        seen = 0;
        foreach (grant_seq[i]) if (grant_seq[i][2]) seen++;
        n_tests++;
        if (seen !== 0 || line_acks !== 1) begin
            n_fail++;
            $display("FAIL late_line1 served2=%0d acks=%0d want 0/1", seen, line_acks);
        end
        fill(4'b0101, 1'b1);
        build_model();
        run_line(FW - 1);
        seen = 0;
        foreach (grant_seq[i]) if (grant_seq[i][2]) seen++;
        n_tests++;
        if (seen !== 1) begin
            n_fail++;
            $display("FAIL late_line2 served2=%0d want 1", seen);
        end
    endtask

    task automatic test_random();
        logic [NR-1:0] a;
        int t [NR];
        for (int l = 0; l < 6; l++) begin
            a = 4'($urandom);
            for (int b = 0; b < NR; b++) t[b] = $urandom_range(1280, 1380);
            for (int i = 0; i < FW; i++) begin
                for (int b = 0; b < NR; b++) req_tab[i][b] = (i < t[b]) ? a[b] : ~a[b];
                en_tab[i] = ($urandom_range(0, 5) != 0);
            end
            build_model();
            run_line(FW - 1);
        end
    endtask

    initial begin
        m_ptr = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_empty();
        test_early_drop();
        test_late_request();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
